wasm_frame_stack: RTL and testbench

- Parametrised successor to the core call stack. Holds WebAssembly function frames of generic width and depth.
- Commands arrive through one valid/ready port: push (call), pop (return), replace (tail call) and unwind-to-depth (exception/trap flush).
- Unwind is a multi-cycle FSM that streams each discarded frame out on a valid/ready port, for backtrace/debug.
- Sits between the control unit and the frame-state registers. Raises exhaustion and underflow traps as registered pulses.

---
 rtl/wasm_frame_stack_pkg.sv | 29 ++
 rtl/wasm_frame_stack_if.sv | 32 +++
 rtl/wasm_frame_stack_mem.sv | 23 ++
 rtl/wasm_frame_stack.sv | 154 +++++++++++++++
 tb/tb_wasm_frame_stack.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/wasm_frame_stack_pkg.sv
// Shared types for the WebAssembly call-frame stack: frame layout, command opcodes and trap codes.
package wasm_frame_stack_pkg;

  localparam int CALL_STACK_DEPTH = 64;

  typedef struct packed {
    logic [7:0] func_idx;
    logic [7:0] ret_slot;
  } frame_entry_t;

  typedef enum logic [1:0] {
    FS_PUSH    = 2'd0,
    FS_POP     = 2'd1,
    FS_REPLACE = 2'd2,
    FS_UNWIND  = 2'd3
  } fstack_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE                 = 2'd0,
    TRAP_CALL_STACK_EXHAUSTED = 2'd1,
    TRAP_CALL_STACK_UNDERFLOW = 2'd2
  } trap_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UNWIND = 1'b1
  } fstack_state_t;

endpackage

// File: rtl/wasm_frame_stack_if.sv
// Command port, pop result and unwind stream of the frame stack; slave = stack, master = control unit.
interface wasm_frame_stack_if
  import wasm_frame_stack_pkg::*;
#(
  parameter int DEPTH   = CALL_STACK_DEPTH,
  parameter int FRAME_W = $bits(frame_entry_t)
);
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic               cmd_valid;
  logic               cmd_ready;
  fstack_op_t         cmd_op;
  logic [FRAME_W-1:0] cmd_frame;
  logic [PTR_W-1:0]   cmd_depth;
  logic               pop_valid;
  logic [FRAME_W-1:0] pop_frame;
  logic               unw_valid;
  logic [FRAME_W-1:0] unw_frame;
  logic               unw_ready;
  logic               unw_done;

  modport master (
    output cmd_valid, cmd_op, cmd_frame, cmd_depth, unw_ready,
    input  cmd_ready, pop_valid, pop_frame, unw_valid, unw_frame, unw_done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_frame, cmd_depth, unw_ready,
    output cmd_ready, pop_valid, pop_frame, unw_valid, unw_frame, unw_done
  );

endinterface

// File: rtl/wasm_frame_stack_mem.sv
// Frame storage: one synchronous write port, one asynchronous read port, contents not reset.
module wasm_frame_stack_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wasm_frame_stack.sv
// WebAssembly call-frame stack with push/pop/replace/unwind commands and trap pulses.
// Optional high-water-mark port enabled by defining WASM_FSTACK_HWM_EN.
//
// state     | meaning
// ST_IDLE   | accepting commands (cmd_ready=1)
// ST_UNWIND | streaming discarded frames until sp reaches the latched target
module wasm_frame_stack
  import wasm_frame_stack_pkg::*;
#(
  parameter int DEPTH   = CALL_STACK_DEPTH,
  parameter int FRAME_W = $bits(frame_entry_t),
  localparam int PTR_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  wasm_frame_stack_if.slave  bus,
  output logic [FRAME_W-1:0] top_frame,
  output logic [PTR_W-1:0]   depth,
  output logic               empty,
  output logic               full,
  output trap_t              trap
`ifdef WASM_FSTACK_HWM_EN
  ,
  output logic [PTR_W-1:0]   hwm
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  fstack_state_t      state;
  logic [PTR_W-1:0]   sp;
  logic [PTR_W-1:0]   sp_next;
  logic [PTR_W-1:0]   target;
  logic               pop_valid_q;
  logic [FRAME_W-1:0] pop_frame_q;
  logic               unw_done_q;
  logic               accept;
  logic               unw_fire;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0]  mem_raddr;
  logic [FRAME_W-1:0] mem_rdata;

  assign empty         = (sp == '0);
  assign full          = (sp == PTR_W'(DEPTH));
  assign depth         = sp;
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.unw_valid = (state == ST_UNWIND);
  assign accept        = bus.cmd_valid && (state == ST_IDLE);
  assign unw_fire      = (state == ST_UNWIND) && bus.unw_ready;
  assign mem_raddr     = empty ? '0 : ADDR_W'(sp - PTR_W'(1));
  assign top_frame     = empty ? '0 : mem_rdata;
  assign bus.unw_frame = top_frame;
  assign bus.pop_valid = pop_valid_q;
  assign bus.pop_frame = pop_frame_q;
  assign bus.unw_done  = unw_done_q;

  // Full/empty guards keep sp and memory untouched on overflow/underflow.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ADDR_W'(sp);
    sp_next   = sp;
    if (accept) begin
      case (bus.cmd_op)
        FS_PUSH: begin
          if (!full) begin
            mem_we  = 1'b1;
            sp_next = sp + PTR_W'(1);
          end
        end
        FS_POP: begin
          if (!empty) sp_next = sp - PTR_W'(1);
        end
        FS_REPLACE: begin
          if (!empty) begin
            mem_we    = 1'b1;
            mem_waddr = mem_raddr;
          end
        end
        default: ;
      endcase
    end else if (unw_fire) begin
      sp_next = sp - PTR_W'(1);
    end
  end

  wasm_frame_stack_mem #(.DEPTH(DEPTH), .W(FRAME_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.cmd_frame),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      sp          <= '0;
      target      <= '0;
      pop_valid_q <= 1'b0;
      pop_frame_q <= '0;
      unw_done_q  <= 1'b0;
      trap        <= TRAP_NONE;
    end else begin
      sp          <= sp_next;
      pop_valid_q <= 1'b0;
      unw_done_q  <= 1'b0;
      trap        <= TRAP_NONE;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              FS_PUSH: if (full) trap <= TRAP_CALL_STACK_EXHAUSTED;
              FS_POP: begin
                if (empty) begin
                  trap <= TRAP_CALL_STACK_UNDERFLOW;
                end else begin
                  pop_valid_q <= 1'b1;
                  pop_frame_q <= mem_rdata;
                end
              end
              FS_REPLACE: if (empty) trap <= TRAP_CALL_STACK_UNDERFLOW;
              FS_UNWIND: begin
                if (bus.cmd_depth > sp) begin
                  trap <= TRAP_CALL_STACK_UNDERFLOW;
                end else if (bus.cmd_depth == sp) begin
                  unw_done_q <= 1'b1;
                end else begin
                  target <= bus.cmd_depth;
                  state  <= ST_UNWIND;
                end
              end
            endcase
          end
        end
        ST_UNWIND: begin
          if (bus.unw_ready && (sp_next == target)) begin
            state      <= ST_IDLE;
            unw_done_q <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef WASM_FSTACK_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm <= '0;
    else if (sp_next > hwm) hwm <= sp_next;
  end
`endif

endmodule

// File: tb/tb_wasm_frame_stack.sv
// Randomized plus directed bench for wasm_frame_stack against a queue-based stack model.
module tb_wasm_frame_stack;
  import wasm_frame_stack_pkg::*;

  localparam int DEPTH   = 4;
  localparam int FRAME_W = 16;
  localparam int PTR_W   = $clog2(DEPTH + 1);
  localparam int UNW_BUDGET = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wasm_frame_stack_if #(.DEPTH(DEPTH), .FRAME_W(FRAME_W)) bus ();

  logic [FRAME_W-1:0] top_frame;
  logic [PTR_W-1:0]   depth;
  logic               empty;
  logic               full;
  trap_t              trap;
`ifdef WASM_FSTACK_HWM_EN
  logic [PTR_W-1:0]   hwm;
`endif

  wasm_frame_stack #(.DEPTH(DEPTH), .FRAME_W(FRAME_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .top_frame (top_frame),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .trap      (trap)
`ifdef WASM_FSTACK_HWM_EN
    ,
    .hwm       (hwm)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [FRAME_W-1:0] mdl_stk[$];
  logic [FRAME_W-1:0] mdl_pop_frame = '0;
  int                 mdl_hwm = 0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [FRAME_W-1:0] mdl_top();
    return (mdl_stk.size() == 0) ? '0 : mdl_stk[mdl_stk.size()-1];
  endfunction

  task automatic check_idle_state(string tag);
    check_eq({tag, "_depth"}, 32'(depth), 32'(mdl_stk.size()));
    check_eq({tag, "_empty"}, 32'(empty), 32'(mdl_stk.size() == 0));
    check_eq({tag, "_full"}, 32'(full), 32'(mdl_stk.size() == DEPTH));
    check_eq({tag, "_top"}, 32'(top_frame), 32'(mdl_top()));
    check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check_eq({tag, "_unw_valid"}, 32'(bus.unw_valid), 32'd0);
`ifdef WASM_FSTACK_HWM_EN
    check_eq({tag, "_hwm"}, 32'(hwm), 32'(mdl_hwm));
`endif
  endtask

  // One command in IDLE; unwinds are drained with a ready pattern or random ready.
  task automatic do_cmd(fstack_op_t op, logic [FRAME_W-1:0] frame, int dep,
                        logic [7:0] rdy_pat, bit use_pat);
    trap_t exp_trap = TRAP_NONE;
    bit    exp_pv   = 1'b0;
    bit    exp_done = 1'b0;
    bit    go_unw   = 1'b0;
    int    cyc      = 0;
    logic  rdy;
    check_eq("pre_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_frame = frame;
    bus.cmd_depth = PTR_W'(dep);
    case (op)
      FS_PUSH: begin
        if (mdl_stk.size() == DEPTH) exp_trap = TRAP_CALL_STACK_EXHAUSTED;
        else mdl_stk.push_back(frame);
      end
      FS_POP: begin
        if (mdl_stk.size() == 0) exp_trap = TRAP_CALL_STACK_UNDERFLOW;
        else begin
          mdl_pop_frame = mdl_stk.pop_back();
          exp_pv = 1'b1;
        end
      end
      FS_REPLACE: begin
        if (mdl_stk.size() == 0) exp_trap = TRAP_CALL_STACK_UNDERFLOW;
        else mdl_stk[mdl_stk.size()-1] = frame;
      end
      FS_UNWIND: begin
        if (dep > mdl_stk.size()) exp_trap = TRAP_CALL_STACK_UNDERFLOW;
        else if (dep == mdl_stk.size()) exp_done = 1'b1;
        else go_unw = 1'b1;
      end
    endcase
    if (mdl_stk.size() > mdl_hwm) mdl_hwm = mdl_stk.size();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check_eq("trap", 32'(trap), 32'(exp_trap));
    check_eq("pop_valid", 32'(bus.pop_valid), 32'(exp_pv));
    check_eq("pop_frame", 32'(bus.pop_frame), 32'(mdl_pop_frame));
    check_eq("unw_done", 32'(bus.unw_done), 32'(exp_done));
    if (go_unw) begin
      while (mdl_stk.size() > dep && cyc < UNW_BUDGET) begin
        rdy = use_pat ? rdy_pat[cyc % 8] : 1'($urandom_range(0, 1));
        bus.unw_ready = rdy;
        check_eq("unw_valid", 32'(bus.unw_valid), 32'd1);
        check_eq("unw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("unw_frame", 32'(bus.unw_frame), 32'(mdl_top()));
        check_eq("unw_depth", 32'(depth), 32'(mdl_stk.size()));
        check_eq("unw_done_early", 32'(bus.unw_done), 32'd0);
        @(posedge clk); #1;
        if (rdy) void'(mdl_stk.pop_back());
        cyc++;
      end
      bus.unw_ready = 1'b0;
      check_eq("unw_within_budget", 32'(cyc < UNW_BUDGET), 32'd1);
      check_eq("unw_done", 32'(bus.unw_done), 32'd1);
    end
    check_idle_state("post_cmd");
    @(posedge clk); #1;
    check_eq("trap_pulse_end", 32'(trap), 32'(TRAP_NONE));
    check_eq("pop_valid_pulse_end", 32'(bus.pop_valid), 32'd0);
    check_eq("unw_done_pulse_end", 32'(bus.unw_done), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = FS_PUSH;
    bus.cmd_frame = '0;
    bus.cmd_depth = '0;
    bus.unw_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_state("reset");
    check_eq("reset_trap", 32'(trap), 32'(TRAP_NONE));
    check_eq("reset_pop_valid", 32'(bus.pop_valid), 32'd0);
    check_eq("reset_pop_frame", 32'(bus.pop_frame), 32'd0);
    check_eq("reset_unw_done", 32'(bus.unw_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, overflow, pop twice, replace.
    do_cmd(FS_PUSH, 16'h1111, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h2222, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h3333, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h4444, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h5555, 0, 8'h00, 1'b0);
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);
    do_cmd(FS_REPLACE, 16'hAAAA, 0, 8'h00, 1'b0);

    // Drain, then underflow on empty.
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);
    do_cmd(FS_REPLACE, 16'hBEEF, 0, 8'h00, 1'b0);

    // Unwind 4 -> 1 with ready 1,0,1,1.
    do_cmd(FS_PUSH, 16'h1111, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h2222, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h3333, 0, 8'h00, 1'b0);
    do_cmd(FS_PUSH, 16'h4444, 0, 8'h00, 1'b0);
    do_cmd(FS_UNWIND, 16'h0000, 1, 8'b0000_1101, 1'b1);

    // Unwind boundaries at depth 2.
    do_cmd(FS_PUSH, 16'h2222, 0, 8'h00, 1'b0);
    do_cmd(FS_UNWIND, 16'h0000, 3, 8'h00, 1'b0);
    do_cmd(FS_UNWIND, 16'h0000, 2, 8'h00, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      fstack_op_t  op;
      r = $urandom_range(0, 9);
      if (r < 4)      op = FS_PUSH;
      else if (r < 6) op = FS_POP;
      else if (r < 8) op = FS_REPLACE;
      else            op = FS_UNWIND;
      do_cmd(op, 16'($urandom), int'($urandom_range(0, DEPTH + 1)), 8'h00, 1'b0);
    end

    // Reset in the middle of an unwind.
    while (mdl_stk.size() < DEPTH) do_cmd(FS_PUSH, 16'($urandom), 0, 8'h00, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = FS_UNWIND;
    bus.cmd_depth = '0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.unw_ready = 1'b1;
    @(posedge clk); #1;
    void'(mdl_stk.pop_back());
    check_eq("mid_unw_valid", 32'(bus.unw_valid), 32'd1);
    check_eq("mid_unw_depth", 32'(depth), 32'(mdl_stk.size()));
`ifdef WASM_FSTACK_HWM_EN
    check_eq("hwm_before_reset", 32'(hwm), 32'(DEPTH));
`endif
    rst_n = 1'b0;
    #2;
    mdl_stk.delete();
    mdl_pop_frame = '0;
    mdl_hwm = 0;
    check_idle_state("async_reset");
    check_eq("async_reset_unw_done", 32'(bus.unw_done), 32'd0);
    @(posedge clk); #1;
    check_eq("reset_hold_unw_done", 32'(bus.unw_done), 32'd0);
    bus.unw_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_state("after_reset");
    check_eq("after_reset_unw_done", 32'(bus.unw_done), 32'd0);
    check_eq("after_reset_trap", 32'(trap), 32'(TRAP_NONE));
    do_cmd(FS_PUSH, 16'h1234, 0, 8'h00, 1'b0);
    do_cmd(FS_POP, 16'h0000, 0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
